conv3x3_mac: RTL and testbench

- Convolution datapath stage directly downstream of the window shifter.
- Consumes each FILTER_SIZE x FILTER_SIZE pixel window and its window_valid strobe.
- Multiplies the window by a runtime-loadable signed kernel, reduces the products through a pipelined adder tree, then rounds, shifts and saturates to an 8-bit output pixel.
- Tracks output-pixel row/column position and flags the last pixel of each frame.

---
 rtl/conv3x3_mac.sv | 141 ++++++++++++++
 tb/tb_conv3x3_mac.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_mac.sv
// 3x3 convolution MAC stage: signed kernel times unsigned pixel window, pipelined
// adder tree, round/shift/saturate to 8 bits, and output row/column tracking.
module conv3x3_mac #(
  parameter int FILTER_SIZE  = 3,
  parameter int IMAGE_WIDTH  = 5,
  parameter int IMAGE_HEIGHT = 5,
  parameter int COEF_W       = 8,
  parameter int ACC_W        = 20,
  parameter int SHIFT        = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  coef_we,
  input  logic [3:0]                            coef_addr,
  input  logic [COEF_W-1:0]                     coef_data,
  input  logic [FILTER_SIZE*FILTER_SIZE*8-1:0]  window_in,
  input  logic                                  window_valid,
  output logic [7:0]                            pixel_out,
  output logic [ACC_W-1:0]                      acc_out,
  output logic                                  pixel_valid,
  output logic [7:0]                            out_col,
  output logic [7:0]                            out_row,
  output logic                                  frame_done,
  output logic                                  busy
);
  localparam int K      = FILTER_SIZE * FILTER_SIZE;
  localparam int PROD_W = COEF_W + 9;
  localparam logic [7:0] COL_LAST = 8'(IMAGE_WIDTH - FILTER_SIZE);
  localparam logic [7:0] ROW_LAST = 8'(IMAGE_HEIGHT - FILTER_SIZE);
  localparam logic signed [ACC_W:0] PIX_MAX = (ACC_W + 1)'(255);

  // Valid semantics: window_valid accepts a window on every edge it is high (no
  // backpressure); pixel_valid marks pixel_out/acc_out/out_row/out_col for one cycle.
  logic signed [COEF_W-1:0] coef [K];
  logic signed [PROD_W-1:0] prod [K];
  logic signed [ACC_W-1:0]  row_sum [FILTER_SIZE];
  logic signed [ACC_W-1:0]  row_comb [FILTER_SIZE];
  logic signed [ACC_W-1:0]  acc, acc_comb;
  logic signed [ACC_W:0]    acc_ext, rounded;
  logic [7:0]               sat_pix;
  logic                     v1, v2, v3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < K; k++) coef[k] <= '0;
    end else if (coef_we) begin
      for (int k = 0; k < K; k++)
        if (coef_addr == 4'(k)) coef[k] <= coef_data;
    end
  end

  // S1: pixel zero-extended, coefficient sign-extended, both to the product width
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      for (int k = 0; k < K; k++) prod[k] <= '0;
    end else begin
      v1 <= window_valid;
      if (window_valid)
        for (int k = 0; k < K; k++)
          prod[k] <= $signed({{(COEF_W + 1){1'b0}}, window_in[k*8 +: 8]}) *
                     $signed({{9{coef[k][COEF_W-1]}}, coef[k]});
    end
  end

  always_comb begin
    for (int r = 0; r < FILTER_SIZE; r++) begin
      row_comb[r] = '0;
      for (int c = 0; c < FILTER_SIZE; c++)
        row_comb[r] = row_comb[r] + ACC_W'(prod[r*FILTER_SIZE + c]);
    end
  end

  always_comb begin
    acc_comb = '0;
    for (int r = 0; r < FILTER_SIZE; r++) acc_comb = acc_comb + row_sum[r];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0;
      v3 <= 1'b0;
      acc <= '0;
      for (int r = 0; r < FILTER_SIZE; r++) row_sum[r] <= '0;
    end else begin
      v2 <= v1;
      v3 <= v2;
      if (v1)
        for (int r = 0; r < FILTER_SIZE; r++) row_sum[r] <= row_comb[r];
      if (v2) acc <= acc_comb;
    end
  end

  // One guard bit so adding the rounding constant cannot overflow
  assign acc_ext = {acc[ACC_W-1], acc};

  if (SHIFT > 0) begin : g_round
    localparam logic signed [ACC_W:0] RND = (ACC_W + 1)'(1) <<< (SHIFT - 1);
    assign rounded = (acc_ext + RND) >>> SHIFT;
  end else begin : g_noround
    assign rounded = acc_ext;
  end

  always_comb begin
    sat_pix = rounded[7:0];
    if (rounded[ACC_W]) sat_pix = 8'd0;
    else if (rounded > PIX_MAX) sat_pix = 8'd255;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_valid <= 1'b0;
      pixel_out   <= '0;
      acc_out     <= '0;
    end else begin
      pixel_valid <= v3;
      if (v3) begin
        pixel_out <= sat_pix;
        acc_out   <= acc;
      end
    end
  end

  // Counters show the pixel being presented and advance at the end of that cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_col <= '0;
      out_row <= '0;
    end else if (pixel_valid) begin
      if (out_col == COL_LAST) begin
        out_col <= '0;
        out_row <= (out_row == ROW_LAST) ? 8'd0 : out_row + 8'd1;
      end else begin
        out_col <= out_col + 8'd1;
      end
    end
  end

  assign frame_done = pixel_valid && (out_row == ROW_LAST) && (out_col == COL_LAST);
  assign busy       = v1 | v2 | v3 | pixel_valid;
endmodule

// File: tb/tb_conv3x3_mac.sv
// Directed bench for conv3x3_mac: SHIFT=0 and SHIFT=3 instances share stimulus;
// expected results go into queues and monitors compare whenever pixel_valid is seen.
module tb_conv3x3_mac;
  localparam int ACC_W = 20;
  localparam int EW    = 61;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = '0;
  logic [7:0]  coef_data = '0;
  logic [71:0] window_in = '0;
  logic        window_valid = 1'b0;

  logic [7:0]       pixel_out, pixel_out3, out_col, out_col3, out_row, out_row3;
  logic [ACC_W-1:0] acc_out, acc_out3;
  logic             pixel_valid, pixel_valid3, frame_done, frame_done3, busy, busy3;

  logic [EW-1:0] exp_q[$];
  logic [7:0]    exp3_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0] m_row = '0;
  logic [7:0] m_col = '0;

  conv3x3_mac #(.SHIFT(0)) u_dut (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .window_in(window_in), .window_valid(window_valid), .pixel_out(pixel_out),
    .acc_out(acc_out), .pixel_valid(pixel_valid), .out_col(out_col), .out_row(out_row),
    .frame_done(frame_done), .busy(busy)
  );

  conv3x3_mac #(.SHIFT(3)) u_dut3 (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .window_in(window_in), .window_valid(window_valid), .pixel_out(pixel_out3),
    .acc_out(acc_out3), .pixel_valid(pixel_valid3), .out_col(out_col3), .out_row(out_row3),
    .frame_done(frame_done3), .busy(busy3)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [71:0] win_seq();
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(k + 1);
    return w;
  endfunction

  function automatic logic [71:0] win_all(input logic [7:0] v);
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = v;
    return w;
  endfunction

  task automatic write_coef(input int k, input logic [7:0] v);
    coef_we = 1'b1;
    coef_addr = 4'(k);
    coef_data = v;
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic load_all(input logic [7:0] v);
    for (int k = 0; k < 9; k++) write_coef(k, v);
  endtask

  // driver: presents one window for one cycle and records what must come out 4 cycles later
  task automatic send(input logic [71:0] w, input int acc, input int p0, input int p3);
    logic fd;
    fd = (m_row == 8'd2) && (m_col == 8'd2);
    window_in = w;
    window_valid = 1'b1;
    exp_q.push_back({16'(cyc + 4), 20'(acc), 8'(p0), m_row, m_col, fd});
    exp3_q.push_back(8'(p3));
    if (m_col == 8'd2) begin
      m_col = 8'd0;
      m_row = (m_row == 8'd2) ? 8'd0 : m_row + 8'd1;
    end else begin
      m_col = m_col + 8'd1;
    end
    @(posedge clk); #1;
    window_valid = 1'b0;
    coef_we = 1'b0;
  endtask

  task automatic issue_only(input logic [71:0] w);
    window_in = w;
    window_valid = 1'b1;
    @(posedge clk); #1;
    window_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (exp_q.size() != 0 || exp3_q.size() != 0); i++) @(posedge clk);
    #1;
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst && pixel_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pixel_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("latency", longint'(cyc), longint'(e[60:45]));
        check("acc_out", longint'($signed(acc_out)), longint'($signed(e[44:25])));
        check("pixel_out", longint'(pixel_out), longint'(e[24:17]));
        check("out_row", longint'(out_row), longint'(e[16:9]));
        check("out_col", longint'(out_col), longint'(e[8:1]));
        check("frame_done", longint'(frame_done), longint'(e[0]));
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] e3;
    if (!rst && pixel_valid3) begin
      if (exp3_q.size() == 0) begin
        check("unexpected_pixel_valid_shift3", 1, 0);
      end else begin
        e3 = exp3_q.pop_front();
        check("pixel_out_shift3", longint'(pixel_out3), longint'(e3));
      end
    end
  end

  // stream table for box kernel, window all = v: shift-3 result (9v+4)>>3
  int stream_p3 [9] = '{1, 2, 3, 5, 6, 7, 8, 9, 10};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_pixel_valid", longint'(pixel_valid), 0);
    check("reset_busy", longint'(busy), 0);
    check("reset_acc_out", longint'(acc_out), 0);
    check("reset_out_col", longint'(out_col), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // streaming: box kernel, 9 back-to-back windows covering a full frame
    load_all(8'd1);
    for (int v = 1; v <= 9; v++) send(win_all(8'(v)), 9 * v, 9 * v, stream_p3[v-1]);
    drain();
    check("stream_out_col_after", longint'(out_col), 0);
    check("stream_out_row_after", longint'(out_row), 0);
    check("stream_frame_done_after", longint'(frame_done), 0);
    check("stream_busy_after", longint'(busy), 0);

    // box kernel on 1..9
    send(win_seq(), 45, 45, 6);
    drain();

    // identity kernel
    load_all(8'd0);
    write_coef(4, 8'd1);
    send(win_seq(), 5, 5, 1);
    drain();

    // positive saturation
    load_all(8'd127);
    send(win_all(8'd255), 291465, 255, 255);
    drain();

    // negative clamp
    load_all(8'hFF);
    send(win_seq(), -45, 0, 0);
    drain();

    // coefficient write coincident with window A; window B sees the new value
    load_all(8'd1);
    coef_we = 1'b1;
    coef_addr = 4'd4;
    coef_data = 8'd2;
    send(win_seq(), 45, 45, 6);
    send(win_seq(), 50, 50, 6);
    drain();

    // writes to indices above 8 must not land anywhere
    coef_we = 1'b1;
    coef_addr = 4'd12;
    coef_data = 8'd100;
    @(posedge clk); #1;
    coef_we = 1'b0;
    send(win_seq(), 50, 50, 6);
    drain();

    // reset with two windows in flight
    issue_only(win_seq());
    issue_only(win_seq());
    rst = 1'b1;
    #1;
    check("rst_busy", longint'(busy), 0);
    check("rst_out_col", longint'(out_col), 0);
    check("rst_out_row", longint'(out_row), 0);
    check("rst_pixel_valid", longint'(pixel_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_row = '0;
    m_col = '0;
    repeat (6) @(posedge clk);
    #1;
    // coefficients cleared by reset, so any window sums to 0
    send(win_seq(), 0, 0, 0);
    drain();

    check("queue_empty", longint'(exp_q.size() + exp3_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
